// File: rtl/afifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: write-pointer sync, level/empty, memory fetch, 2-entry output stage.
// Optional almost_empty flag is built when AFIFO_RD_ALMOST_EMPTY_EN is defined.
module afifo_rd_ctrl #(
    parameter int unsigned AW       = 4,
    parameter int unsigned DW       = 8,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW:0]   wptr_gray_i,
    input  logic [DW-1:0] rdata_mem_i,
    output logic          rd_mem_en,
    output logic [AW-1:0] rd_addr,
    output logic [AW:0]   rptr_gray_o,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    input  logic          o_ready,
    output logic          empty,
    output logic [AW:0]   rd_level
`ifdef AFIFO_RD_ALMOST_EMPTY_EN
    ,
    output logic          almost_empty
`endif
);

    localparam int unsigned PW = AW + 1;

    logic [AW:0]   wsync1_q, wsync2_q;
    logic [AW:0]   wbin;
    logic [AW:0]   rbin_q, rbin_d;
    logic [DW-1:0] skid_q, skid_d, o_data_d;
    logic          skid_vld_q, skid_vld_d, o_valid_d;
    logic [1:0]    occ;
    logic          pop;

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = int'(AW) - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Level, empty and fetch decision; a fetch is allowed only if the output stage can absorb it
    always_comb begin
        wbin      = gray2bin(wsync2_q);
        rd_level  = wbin - rbin_q;
        empty     = (rd_level == '0);
        pop       = o_valid & o_ready;
        occ       = 2'(o_valid) + 2'(skid_vld_q);
        rd_mem_en = !empty && ((occ - 2'(pop)) < 2'd2);
        rd_addr   = rbin_q[AW-1:0];
        rbin_d    = rbin_q + PW'(rd_mem_en);
    end

    // Output register plus skid: pop shifts skid forward, fetched word fills the first free slot
    always_comb begin
        o_valid_d  = o_valid;
        o_data_d   = o_data;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (pop) begin
            o_valid_d  = skid_vld_q;
            o_data_d   = skid_vld_q ? skid_q : o_data;
            skid_vld_d = 1'b0;
        end
        if (rd_mem_en) begin
            if (!o_valid_d) begin
                o_valid_d = 1'b1;
                o_data_d  = rdata_mem_i;
            end else begin
                skid_vld_d = 1'b1;
                skid_d     = rdata_mem_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wsync1_q    <= '0;
            wsync2_q    <= '0;
            rbin_q      <= '0;
            rptr_gray_o <= '0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            skid_vld_q  <= 1'b0;
            skid_q      <= '0;
        end else begin
            wsync1_q    <= wptr_gray_i;
            wsync2_q    <= wsync1_q;
            rbin_q      <= rbin_d;
            rptr_gray_o <= rbin_d ^ (rbin_d >> 1);
            o_valid     <= o_valid_d;
            o_data      <= o_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_q      <= skid_d;
        end
    end

`ifdef AFIFO_RD_ALMOST_EMPTY_EN
    // Registered from the post-edge level so the flag tracks rd_level without a cycle of lag
    logic [AW:0] level_d;
    assign level_d = gray2bin(wsync1_q) - rbin_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_empty <= 1'b1;
        end else begin
            almost_empty <= (level_d <= PW'(AE_LEVEL));
        end
    end
`endif

endmodule

// File: tb/tb_afifo_rd_ctrl.sv
// Randomized self-checking bench for afifo_rd_ctrl against a word-count reference model.
module tb_afifo_rd_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned PW = AW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW:0]   wptr_gray_i;
    logic [DW-1:0] rdata_mem_i;
    logic          rd_mem_en;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   rptr_gray_o;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_ready;
    logic          empty;
    logic [AW:0]   rd_level;
`ifdef AFIFO_RD_ALMOST_EMPTY_EN
    logic          almost_empty;
`endif

    afifo_rd_ctrl #(.AW(AW), .DW(DW), .AE_LEVEL(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wptr_gray_i (wptr_gray_i),
        .rdata_mem_i (rdata_mem_i),
        .rd_mem_en   (rd_mem_en),
        .rd_addr     (rd_addr),
        .rptr_gray_o (rptr_gray_o),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_ready     (o_ready),
        .empty       (empty),
        .rd_level    (rd_level)
`ifdef AFIFO_RD_ALMOST_EMPTY_EN
        ,
        .almost_empty(almost_empty)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [16];
    assign rdata_mem_i = mem[rd_addr];

    int            n_checks = 0;
    int            n_errors = 0;
    int            wcnt, popped, rcnt, ws1, wsyn, nbuf;
    int            run, max_run, dut_reads, r0, lvl;
    bit            ev, ep, een;
    logic [DW-1:0] expq [$];
    logic [AW-1:0] addr_log [$];
    int            exp_addr [4] = '{14, 15, 0, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW:0] gray(input int v);
        logic [AW:0] b;
        b = PW'(v);
        return b ^ (b >> 1);
    endfunction

    // Reference model: counts of words written, seen by the reader, fetched and buffered
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", 32'(o_valid), 0);
            check("rst_data", 32'(o_data), 0);
            check("rst_en", 32'(rd_mem_en), 0);
            check("rst_rptr", 32'(rptr_gray_o), 0);
            check("rst_level", 32'(rd_level), 0);
            check("rst_empty", 32'(empty), 1);
`ifdef AFIFO_RD_ALMOST_EMPTY_EN
            check("rst_ae", 32'(almost_empty), 1);
`endif
            ws1 = 0; wsyn = 0; rcnt = 0; nbuf = 0; run = 0;
        end else begin
            lvl = wsyn - rcnt;
            ev  = (nbuf > 0);
            ep  = ev && o_ready;
            een = (lvl > 0) && ((nbuf - int'(ep)) < 2);
            check("level", 32'(rd_level), 32'(lvl));
            check("empty", 32'(empty), 32'(lvl == 0));
            check("valid", 32'(o_valid), 32'(ev));
            check("rd_en", 32'(rd_mem_en), 32'(een));
            check("rptr", 32'(rptr_gray_o), 32'(gray(rcnt)));
            if (een) check("rd_addr", 32'(rd_addr), 32'(rcnt % 16));
            if (ev && expq.size() > 0) check("data", 32'(o_data), 32'(expq[0]));
`ifdef AFIFO_RD_ALMOST_EMPTY_EN
            check("ae", 32'(almost_empty), 32'(lvl <= 2));
`endif
            if (rd_mem_en === 1'b1) begin
                dut_reads++;
                addr_log.push_back(rd_addr);
            end
            run = (o_valid === 1'b1) ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (ep) begin
                if (expq.size() > 0) void'(expq.pop_front());
                nbuf--;
                popped++;
            end
            if (een) begin
                nbuf++;
                rcnt++;
            end
            wsyn = ws1;
            ws1  = wcnt;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic write_word();
        logic [DW-1:0] d;
        d = DW'($urandom);
        mem[wcnt % 16] = d;
        expq.push_back(d);
        wcnt++;
        wptr_gray_i = gray(wcnt);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wcnt = 0;
        popped = 0;
        expq.delete();
        wptr_gray_i = '0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        rst_n = 1'b0; o_ready = 1'b0; wptr_gray_i = '0;
        wcnt = 0; popped = 0; dut_reads = 0; max_run = 0; run = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset with two words already posted (Gray 00011)
        write_word();
        write_word();
        tick(3);
        o_ready = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_e0_en", 32'(rd_mem_en), 0);
        @(posedge clk); #1;
        check("rel_e1_en", 32'(rd_mem_en), 1);
        #1;
        tick(8);
        check("rel_rptr", 32'(rptr_gray_o), 32'(5'b00011));
        check("rel_drained", 32'(expq.size()), 0);

        // Single word
        do_reset();
        o_ready = 1'b1;
        r0 = dut_reads; max_run = 0;
        write_word();
        tick(8);
        check("single_reads", 32'(dut_reads - r0), 1);
        check("single_vrun", 32'(max_run), 1);
        check("single_rptr", 32'(rptr_gray_o), 32'(5'b00001));
        check("single_empty", 32'(empty), 1);

        // Burst of 16
        do_reset();
        r0 = dut_reads; max_run = 0;
        repeat (16) write_word();
        tick(24);
        check("burst_reads", 32'(dut_reads - r0), 16);
        check("burst_vrun", 32'(max_run), 16);
        check("burst_rptr", 32'(rptr_gray_o), 32'(5'b11000));

        // Backpressure
        o_ready = 1'b0;
        r0 = dut_reads;
        repeat (4) write_word();
        tick(10);
        check("bp_reads", 32'(dut_reads - r0), 2);
        check("bp_valid", 32'(o_valid), 1);
        check("bp_hold", 32'(o_data), 32'(expq[0]));
        run = 0; max_run = 0;
        o_ready = 1'b1;
        tick(10);
        check("bp_run", 32'(max_run), 4);
        check("bp_drained", 32'(expq.size()), 0);

        // Pointer wrap: bring rbin to 30, then four more
        repeat (10) write_word();
        tick(20);
        addr_log.delete();
        repeat (4) write_word();
        tick(12);
        check("wrap_nreads", 32'(addr_log.size()), 4);
        if (addr_log.size() >= 4)
            for (int i = 0; i < 4; i++) check("wrap_addr", 32'(addr_log[i]), 32'(exp_addr[i]));
        check("wrap_rptr", 32'(rptr_gray_o), 32'(5'b00011));

        // Random traffic and backpressure
        for (int c = 0; c < 400; c++) begin
            o_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                int n;
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++)
                    if (wcnt - popped < 16) write_word();
            end
            tick(1);
        end
        o_ready = 1'b1;
        tick(30);
        check("rand_drained", 32'(expq.size()), 0);

        // Reset while reads are outstanding
        o_ready = 1'b0;
        repeat (4) write_word();
        tick(3);
        rst_n = 1'b0;
        wcnt = 0; popped = 0; expq.delete(); wptr_gray_i = '0;
        tick(2);
        rst_n = 1'b1;
        o_ready = 1'b1;
        tick(3);
        repeat (3) write_word();
        tick(12);
        check("mid_rst_rptr", 32'(rptr_gray_o), 32'(gray(3)));
        check("mid_rst_drained", 32'(expq.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
